// File: rtl/sprite_pkg.sv
// Shared sprite-path types and constants: pixel/address types, ROM size, arbiter states.
package sprite_pkg;

    localparam int PIX_W           = 12;
    localparam int SPRITE_ADDR_W   = 8;
    localparam int SPRITE_ROM_SIZE = 240;

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;

    localparam pixel_t PIX_TRANSPARENT = 12'h000;

    typedef enum logic {
        IDLE_RR = 1'b0,
        LOCKED  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set req bit at or above ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; the caller owns ptr and decides when it advances.
module rr_pick
    import sprite_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any         = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sync sprite ROM, with LOCK_MAX-bounded burst locks (SPRITE_ROM_ADDR_CHECK_EN adds range check).
// Latency: grant combinational; rvalid/rdata exactly one cycle after gnt, one read per cycle.
// Backpressure: a requester holds req until gnt; no response-side stall exists.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = PIX_W,
    parameter int ADDR_WIDTH = SPRITE_ADDR_W,
    parameter int ROM_SIZE   = SPRITE_ROM_SIZE,
    parameter int LOCK_MAX   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [NUM_REQ-1:0]            err,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] rvalid_q;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  lock_cont;
    logic                  any_gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  oob;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // The owner keeps the ROM only while it still asks, still locks and has burst budget left.
    assign lock_cont = (state_q == LOCKED) && req[owner_q] && lock[owner_q]
                       && (burst_cnt_q < CNT_W'(LOCK_MAX - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE_RR;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= gnt;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (lock_cont) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else if (pick_any) begin
            rr_ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            burst_cnt_d = '0;
            owner_d     = pick_idx;
            state_d     = lock[pick_idx] ? LOCKED : IDLE_RR;
        end else begin
            state_d     = IDLE_RR;
            burst_cnt_d = '0;
        end
    end

    // Outputs are gated by reset_n so an asserted reset silences gnt and rom_addr at once.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        if (reset_n) begin
            if (lock_cont) begin
                gnt[owner_q] = 1'b1;
                gnt_idx      = owner_q;
                any_gnt      = 1'b1;
            end else if (pick_any) begin
                gnt     = pick_oh;
                gnt_idx = pick_idx;
                any_gnt = 1'b1;
            end
        end
    end

    assign sel_addr = addr_arr[gnt_idx];
    assign rom_addr = (any_gnt && !oob) ? sel_addr : '0;
    assign rvalid   = rvalid_q;

`ifdef SPRITE_ROM_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] ROM_LIMIT = ROM_SIZE[ADDR_WIDTH:0];

    logic [NUM_REQ-1:0] err_q;

    assign oob = any_gnt && ({1'b0, sel_addr} >= ROM_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else begin
            err_q <= oob ? gnt : '0;
        end
    end

    assign err   = err_q;
    // Out-of-range reads return a transparent pixel instead of whatever sits at ROM address 0.
    assign rdata = ((|rvalid_q) && !(|err_q)) ? rom_data : DATA_WIDTH'(PIX_TRANSPARENT);
`else
    logic [31:0] unused_rom_size;

    assign unused_rom_size = ROM_SIZE;
    assign oob   = 1'b0;
    assign err   = '0;
    assign rdata = (|rvalid_q) ? rom_data : DATA_WIDTH'(PIX_TRANSPARENT);
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed and randomized bench for sprite_rom_arbiter against a grant-level reference model.
module tb_sprite_rom_arbiter;

    localparam int N  = 2;
    localparam int DW = 12;
    localparam int AW = 8;
    localparam int RS = 240;
    localparam int LM = 16;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic [AW-1:0] addr [N];
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic [DW-1:0] rdata;
    logic [N-1:0]  err;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    logic [DW-1:0] rom_mem [256];

    int checks;
    int failures;

    // reference model: pointer, current owner (-1 none) and grants issued in its burst
    int m_ptr, m_owner, m_run, m_prev_g, m_prev_addr;
    bit m_prev_oob, m_cont;

    logic [N-1:0]  obs_gnt, obs_rvalid, obs_err;
    logic [DW-1:0] obs_rdata;
    logic [AW-1:0] obs_addr;

    assign req_addr = {addr[1], addr[0]};

    sprite_rom_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ROM_SIZE   (RS),
        .LOCK_MAX   (LM)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .lock     (lock),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .err      (err),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr       = 0;
        m_owner     = -1;
        m_run       = 0;
        m_prev_g    = -1;
        m_prev_addr = 0;
        m_prev_oob  = 1'b0;
        m_cont      = 1'b0;
    endtask

    function automatic int model_grant();
        m_cont = 1'b0;
        if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_run < LM) begin
            m_cont = 1'b1;
            return m_owner;
        end
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // one clock: sample at negedge, compare against the model, advance to posedge+1
    task automatic cycle(input string tag, output int g);
        bit            oob;
        int            ea;
        logic [N-1:0]  eg, ev, ee;
        logic [DW-1:0] ed;
        @(negedge clk);
        g   = model_grant();
        oob = 1'b0;
`ifdef SPRITE_ROM_ADDR_CHECK_EN
        if (g >= 0 && int'(addr[g]) >= RS) oob = 1'b1;
`endif
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        ea = (g >= 0 && !oob) ? int'(addr[g]) : 0;
        ev = '0;
        if (m_prev_g >= 0) ev[m_prev_g] = 1'b1;
        ee = m_prev_oob ? ev : '0;
        ed = (m_prev_g >= 0 && !m_prev_oob) ? rom_mem[m_prev_addr] : '0;
        obs_gnt    = gnt;
        obs_addr   = rom_addr;
        obs_rvalid = rvalid;
        obs_rdata  = rdata;
        obs_err    = err;
        chk($sformatf("%s.gnt", tag), 32'(gnt), 32'(eg));
        chk($sformatf("%s.rom_addr", tag), 32'(rom_addr), 32'(ea));
        chk($sformatf("%s.rvalid", tag), 32'(rvalid), 32'(ev));
        chk($sformatf("%s.rdata", tag), 32'(rdata), 32'(ed));
        chk($sformatf("%s.err", tag), 32'(err), 32'(ee));
        if (g >= 0) begin
            if (m_cont) begin
                m_run++;
            end else begin
                m_ptr = (g + 1) % N;
                if (lock[g]) begin
                    m_owner = g;
                    m_run   = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end else begin
            m_owner = -1;
        end
        m_prev_g    = g;
        m_prev_addr = ea;
        m_prev_oob  = oob;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        lock    = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int g;
        bit [N-1:0] pend;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);
        rom_mem[5]   = 12'hF00;
        rom_mem[240] = 12'hABC;
        addr[0]  = 8'h00;
        addr[1]  = 8'h00;
        reset_n  = 1'b0;
        req      = 2'b11;
        lock     = 2'b11;
        model_reset();

        // reset state, with requests already pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.gnt", 32'(gnt), 32'h0);
        chk("reset.rvalid", 32'(rvalid), 32'h0);
        chk("reset.rdata", 32'(rdata), 32'h0);
        chk("reset.rom_addr", 32'(rom_addr), 32'h0);
        chk("reset.err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req     = '0;
        lock    = '0;
        model_reset();

        for (int c = 0; c < 10; c++) cycle("idle", g);

        // single read of ROM[5]
        req     = 2'b01;
        addr[0] = 8'h05;
        cycle("single0", g);
        chk("single.gnt", 32'(obs_gnt), 32'h1);
        chk("single.rom_addr", 32'(obs_addr), 32'h05);
        req = '0;
        cycle("single1", g);
        chk("single.rvalid", 32'(obs_rvalid), 32'h1);
        chk("single.rdata", 32'(obs_rdata), 32'hF00);

        // fairness from reset
        do_reset();
        req     = 2'b11;
        addr[0] = 8'h10;
        addr[1] = 8'h20;
        for (int c = 0; c < 6; c++) begin
            cycle("fair", g);
            chk("fair.seq", 32'(obs_gnt), (c % 2 == 0) ? 32'h1 : 32'h2);
        end
        req = '0;
        cycle("fair_drain", g);

        // lock limit: rr_ptr=1 after granting port 0 once
        req = 2'b01;
        cycle("lk_pre", g);
        req  = 2'b11;
        lock = 2'b10;
        for (int c = 0; c < 18; c++) begin
            addr[1] = AW'(c + 30);
            cycle("lock", g);
            chk("lock.seq", 32'(obs_gnt), (c == 16) ? 32'h1 : 32'h2);
        end
        req  = '0;
        lock = '0;
        cycle("lock_drain", g);

        // reset mid-burst discards the pending response
        req     = 2'b01;
        lock    = 2'b01;
        addr[0] = 8'h07;
        cycle("mid0", g);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid.rvalid", 32'(rvalid), 32'h0);
        chk("mid.gnt", 32'(gnt), 32'h0);
        chk("mid.rdata", 32'(rdata), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        req     = 2'b10;
        lock    = '0;
        addr[1] = 8'h09;
        cycle("mid1", g);
        chk("mid.first_gnt", 32'(obs_gnt), 32'h2);
        req = '0;
        cycle("mid_drain", g);

        // out-of-range address
        req     = 2'b01;
        addr[0] = 8'd240;
        cycle("oob0", g);
`ifdef SPRITE_ROM_ADDR_CHECK_EN
        chk("oob.rom_addr", 32'(obs_addr), 32'h0);
`else
        chk("oob.rom_addr", 32'(obs_addr), 32'd240);
`endif
        req = '0;
        cycle("oob1", g);
        chk("oob.rvalid", 32'(obs_rvalid), 32'h1);
`ifdef SPRITE_ROM_ADDR_CHECK_EN
        chk("oob.err", 32'(obs_err), 32'h1);
        chk("oob.rdata", 32'(obs_rdata), 32'h0);
`else
        chk("oob.err", 32'(obs_err), 32'h0);
        chk("oob.rdata", 32'(obs_rdata), 32'hABC);
`endif

        // randomized traffic; each request is held until granted
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    pend[i] = ($urandom % 3) != 0;
                    addr[i] = AW'($urandom);
                end
                lock[i] = ($urandom % 4) != 0;
            end
            req = pend;
            cycle("rand", g);
            if (g >= 0) pend[g] = 1'b0;
        end
        req  = '0;
        lock = '0;
        cycle("rand_drain", g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port synchronous sprite ROM among NUM_REQ requesters. Typical requesters are the VGA pixel fetch path, the HUD life-icon drawer and the splash loader.
- The ROM registers its address on the clock edge and has 1-cycle read latency.
- Arbitration is round-robin, one grant per cycle.
- Supports locked bursts so a requester can stream a sprite row without interleaving, bounded by LOCK_MAX to prevent starvation.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_WIDTH, 12, ROM word width (RGB444 pixel).
- ADDR_WIDTH, 8, ROM address width.
- ROM_SIZE, 240, number of valid ROM entries.
- LOCK_MAX, 16, max consecutive grants to one locked requester.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester read request; held until granted.
- lock  in  NUM_REQ  per-requester burst-lock hint; sampled only for the current owner.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  out  NUM_REQ  one-hot combinational grant; the request is accepted this cycle.
- rvalid  out  NUM_REQ  one-hot registered; read data for that requester is valid this cycle.
- rdata  out  DATA_WIDTH  shared read data; 0 when no rvalid bit is set.
- err  out  NUM_REQ  one-hot, coincident with rvalid; out-of-range access (see Optional Feature).
- rom_addr  out  ADDR_WIDTH  address to the ROM; the granted requester's address, else 0.
- rom_data  in  DATA_WIDTH  ROM read data; corresponds to rom_addr of the previous cycle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rr_ptr=0, owner=none, burst_cnt=0, rvalid_q=0, err_q=0.
  - gnt, rvalid, err forced 0; rom_addr=0; rdata=0.
- Arbitration (combinational each cycle):
  - If an owner exists, req[owner]=1, lock[owner]=1 and burst_cnt<LOCK_MAX-1: grant owner.
  - Otherwise grant the first requester with req=1, searching from rr_ptr upward modulo NUM_REQ.
  - No req: gnt=0, rom_addr=0.
- Grant side effects (registered at the edge):
  - rr_ptr <= (granted index+1) mod NUM_REQ on every non-locked grant. rr_ptr is unchanged on lock-continuation grants.
  - Granted requester with lock=1 becomes owner. burst_cnt <= 0 on ownership start; +1 on each continuation grant.
  - Owner is released when: lock drops, req drops, a grant goes elsewhere, or burst_cnt reaches LOCK_MAX-1.
  - On release by LOCK_MAX the next grant must go round-robin excluding nothing. rr_ptr already points past the owner, so the owner loses at least one cycle if any other req is high.
- Read data:
  - rvalid_q <= gnt each edge, so rvalid is exactly 1 cycle after gnt.
  - rdata = rom_data when |rvalid, else 0.
  - Back-to-back grants give one response per cycle, in order; no bubbles.
- Throughput and state:
  - 1 read/cycle sustained.
  - Controller has 2 states: IDLE_RR (no owner) and LOCKED (owner valid). IDLE_RR→LOCKED on a grant with lock=1. LOCKED→IDLE_RR on any release condition above.
- Boundary conditions:
  - Simultaneous req on all ports with rr_ptr=k: port k wins.
  - A requester dropping req in the same cycle as gnt is a protocol violation; the bench asserts req stays high until gnt.
  - Reset asserted mid-burst: the pending rvalid is discarded (rvalid=0 next cycle); the requester must reissue.
  - NUM_REQ=1: always granted when req; lock limit still applies but has no observable effect.

Optional Feature:
- Macro: SPRITE_ROM_ADDR_CHECK_EN.
- Defined: a granted address >= ROM_SIZE is still granted, but rom_addr is driven 0. The next cycle's response has rdata=0 (transparent) and err bit = rvalid bit.
- Undefined: address passes through unchecked; err tied to 0; ROM contents beyond ROM_SIZE are undefined.

Decomposition:
- Shared package sprite_pkg holds:
  - pixel_t (DATA_WIDTH logic).
  - sprite_addr_t.
  - constants SPRITE_ROM_SIZE=240 and PIX_TRANSPARENT=12'h000.
  - arb_state_e enum {IDLE_RR, LOCKED}.
- One natural sub-module: rr_pick. It is a combinational round-robin priority picker with inputs req and ptr, and outputs one-hot plus index. It is reused by the upcoming VGA layer mixer.

Test Plan:
- Single read: req[0]=1, addr 8'h05, ROM[5]=12'hF00 → gnt[0] at cycle 0; rvalid[0]=1, rdata=12'hF00 at cycle 1; rom_addr=8'h05 at cycle 0.
- Fairness: req=2'b11 held 6 cycles from reset → gnt sequence 01,10,01,10,01,10; rvalid trails by 1 with the matching ROM words.
- Lock limit: req=2'b11, lock[1]=1, rr_ptr=1, LOCK_MAX=16 → 16 consecutive gnt[1], then gnt[0] once, then gnt[1] resumes.
- Reset mid-burst: assert reset_n=0 one cycle after gnt[0] → rvalid=0, gnt=0, rdata=0 immediately; after release, req[1] alone wins at first cycle.
- Address check (macro defined): req[0] addr 8'd240 → rom_addr=0, next cycle rvalid[0]=1, err[0]=1, rdata=12'h000. Macro undefined → err stays 0.
- Idle: req=0 for 10 cycles → gnt=0, rvalid=0, rdata=0, rom_addr=0 throughout.
